timepulse_monitor: RTL

- Receiving end of the sequence_generator timing-pulse interface: samples tp1..tp11 on every clk edge and checks that exactly one pulse is active, stepping tp1->tp2->...->tp11->tp1.
- Produces a binary pulse index, lock status, a memory-cycle start strobe and counter, and sequence-error reporting.
- Sits beside the sequence generator and feeds the control-pulse and memory-timing logic.

---
 rtl/timepulse_monitor.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/timepulse_monitor.sv
// Timing-pulse monitor: tracks the tp1..tp11 one-hot cascade from the sequence generator.
// Build option: define TP_STALL_EN to treat an all-zero sample in TRACK/LOCKED as a stall.
module timepulse_monitor #(
  parameter int LOCK_COUNT = 4,
  parameter int COUNT_W    = 16,
  parameter int ERR_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tp1,
  input  logic               tp2,
  input  logic               tp3,
  input  logic               tp4,
  input  logic               tp5,
  input  logic               tp6,
  input  logic               tp7,
  input  logic               tp8,
  input  logic               tp9,
  input  logic               tp10,
  input  logic               tp11,
  output logic [3:0]         tp_index,
  output logic               locked,
  output logic               cycle_start,
  output logic [COUNT_W-1:0] mct_count,
  output logic               seq_error,
  output logic [ERR_W-1:0]   error_count
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N    = 4'(LOCK_COUNT);
  localparam logic [3:0] IDX_ZERO  = 4'd0;
  localparam logic [3:0] IDX_MULTI = 4'd15;

`ifdef TP_STALL_EN
  localparam logic STALL_EN = 1'b1;
`else
  localparam logic STALL_EN = 1'b0;
`endif

  // 1..11 for a one-hot sample, 0 for none high, 15 for two or more high.
  function automatic logic [3:0] tp_class(input logic [10:0] v);
    logic [3:0] cnt;
    logic [3:0] idx;
    cnt = 4'd0;
    idx = 4'd0;
    for (int i = 0; i < 11; i++) begin
      cnt = cnt + {3'b000, v[i]};
      idx = v[i] ? 4'(i + 1) : idx;
    end
    if (cnt == 4'd0) begin
      return IDX_ZERO;
    end else if (cnt == 4'd1) begin
      return idx;
    end else begin
      return IDX_MULTI;
    end
  endfunction

  function automatic logic [3:0] next_expected(input logic [3:0] e);
    return (e == 4'd11) ? 4'd1 : e + 4'd1;
  endfunction

  logic [10:0]        sample_s;
  logic [3:0]         idx_s;
  logic               stall_s;
  logic               match_s;
  logic               is_tp1_s;

  state_t             state_r, state_s;
  logic [3:0]         expected_r, expected_s;
  logic [3:0]         good_r, good_s;
  logic [3:0]         tp_index_r;
  logic               locked_r;
  logic               cycle_start_r, cycle_start_s;
  logic               seq_error_r, seq_error_s;
  logic [COUNT_W-1:0] mct_count_r, mct_count_s;
  logic [ERR_W-1:0]   error_count_r, error_count_s;

  assign sample_s = {tp11, tp10, tp9, tp8, tp7, tp6, tp5, tp4, tp3, tp2, tp1};
  assign idx_s    = tp_class(sample_s);
  assign stall_s  = STALL_EN && (idx_s == IDX_ZERO);
  assign match_s  = (idx_s == expected_r);
  assign is_tp1_s = (idx_s == 4'd1);

  // Next-state and strobe decode for the lock FSM.
  always_comb begin
    state_s       = state_r;
    expected_s    = expected_r;
    good_s        = good_r;
    cycle_start_s = 1'b0;
    seq_error_s   = 1'b0;
    mct_count_s   = mct_count_r;
    error_count_s = error_count_r;

    case (state_r)
      HUNT: begin
        if (is_tp1_s) begin
          state_s    = TRACK;
          expected_s = 4'd2;
          good_s     = 4'd1;
        end else begin
          expected_s = 4'd1;
          good_s     = 4'd0;
        end
      end

      TRACK: begin
        if (stall_s) begin
          state_s = TRACK;
        end else if (match_s) begin
          // good counts tp1 itself, so LOCK_COUNT further pulses lock when good_r equals LOCK_N.
          good_s     = good_r + 4'd1;
          expected_s = next_expected(expected_r);
          if (good_r >= LOCK_N) begin
            state_s = LOCKED;
          end else begin
            state_s = TRACK;
          end
        end else if (is_tp1_s) begin
          state_s    = TRACK;
          expected_s = 4'd2;
          good_s     = 4'd1;
        end else begin
          state_s    = HUNT;
          expected_s = 4'd1;
          good_s     = 4'd0;
        end
      end

      LOCKED: begin
        if (stall_s) begin
          state_s = LOCKED;
        end else if (match_s) begin
          expected_s = next_expected(expected_r);
          if (is_tp1_s) begin
            cycle_start_s = 1'b1;
            mct_count_s   = mct_count_r + COUNT_W'(1);
          end else begin
            cycle_start_s = 1'b0;
          end
        end else begin
          seq_error_s = 1'b1;
          if (error_count_r != {ERR_W{1'b1}}) begin
            error_count_s = error_count_r + ERR_W'(1);
          end else begin
            error_count_s = error_count_r;
          end
          if (is_tp1_s) begin
            state_s    = TRACK;
            expected_s = 4'd2;
            good_s     = 4'd1;
          end else begin
            state_s    = HUNT;
            expected_s = 4'd1;
            good_s     = 4'd0;
          end
        end
      end

      default: begin
        state_s    = HUNT;
        expected_s = 4'd1;
        good_s     = 4'd0;
      end
    endcase
  end

  // State and output registers; reset discards the sample taken on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= HUNT;
      expected_r    <= 4'd1;
      good_r        <= 4'd0;
      tp_index_r    <= 4'd0;
      locked_r      <= 1'b0;
      cycle_start_r <= 1'b0;
      seq_error_r   <= 1'b0;
      mct_count_r   <= {COUNT_W{1'b0}};
      error_count_r <= {ERR_W{1'b0}};
    end else begin
      state_r       <= state_s;
      expected_r    <= expected_s;
      good_r        <= good_s;
      tp_index_r    <= idx_s;
      locked_r      <= (state_s == LOCKED);
      cycle_start_r <= cycle_start_s;
      seq_error_r   <= seq_error_s;
      mct_count_r   <= mct_count_s;
      error_count_r <= error_count_s;
    end
  end

  assign tp_index    = tp_index_r;
  assign locked      = locked_r;
  assign cycle_start = cycle_start_r;
  assign seq_error   = seq_error_r;
  assign mct_count   = mct_count_r;
  assign error_count = error_count_r;

  timepulse_monitor_checker u_chk (
    .clk         (clk),
    .reset       (reset),
    .locked      (locked_r),
    .cycle_start (cycle_start_r),
    .seq_error   (seq_error_r)
  );

endmodule

// Output-consistency properties for the monitor strobes.
module timepulse_monitor_checker (
  input logic clk,
  input logic reset,
  input logic locked,
  input logic cycle_start,
  input logic seq_error
);

  // A cycle start implies lock; an error implies loss of lock; never both strobes.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(cycle_start && seq_error)) else $error("strobe overlap");
      assert (!cycle_start || locked) else $error("cycle_start without lock");
      assert (!seq_error || !locked) else $error("seq_error while locked");
    end
  end

endmodule
